// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_pkg
//  Description : Shared types and defaults for the RVV vector register file.
//                Holds default geometry, the register index type and the
//                sweep/run state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_pkg;

  localparam int DLEN_DEF = 128;
  localparam int NREG_DEF = 32;

  typedef logic [$clog2(NREG_DEF)-1:0] vreg_addr_t;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } vrf_state_e;

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_be_merge.sv
`default_nettype none
// ============================================================================
//  Module      : vec_be_merge
//  Description : Combinational byte-enable priority merge. Starts from a base
//                word and overlays the bytes selected by each enabled,
//                address-matching port; the highest-indexed port wins a byte.
//  Ports       : base_i    - word before the write
//                en_i      - per-port write strobe
//                match_i   - per-port address match for this word
//                be_i      - per-port byte enables
//                data_i    - per-port write data
//                merged_o  - word after the write
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_be_merge
  import vec_pkg::*;
#(
  parameter int DLEN  = DLEN_DEF,
  parameter int WPORT = 2
) (
  input  logic [DLEN-1:0]                  base_i,
  input  logic [WPORT-1:0]                 en_i,
  input  logic [WPORT-1:0]                 match_i,
  input  logic [WPORT-1:0][DLEN/8-1:0]     be_i,
  input  logic [WPORT-1:0][DLEN-1:0]       data_i,
  output logic [DLEN-1:0]                  merged_o
);

  // Ascending port order: a later port overwrites an earlier one.
  always_comb begin
    merged_o = base_i;
    for (int p = 0; p < WPORT; p++) begin
      for (int b = 0; b < DLEN/8; b++) begin
        if (en_i[p] && match_i[p] && be_i[p][b]) begin
          merged_o[8*b +: 8] = data_i[p][8*b +: 8];
        end
      end
    end
  end

endmodule : vec_be_merge
`default_nettype wire

// File: rtl/vec_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : vec_regfile
//  Description : Multi-port vector register file. NREG x DLEN flop storage,
//                WPORT byte-enabled write ports, RPORT registered read ports
//                with write-first bypass, and a zeroing sweep after reset or
//                soft clear.
//  Ports       : clk, rst       - clock, synchronous active-high reset
//                clk_en_i       - global enable; all state holds when low
//                clr_i          - soft clear request (restarts the sweep)
//                wr_en_i/wr_be_i/wr_addr_i/wr_data_i - write ports
//                rd_en_i/rd_addr_i - read requests
//                rd_data_o      - registered read data
//                busy_o         - sweep in progress, accesses not serviced
//                wr_conflict_o  - overlapping same-register writes last cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_regfile
  import vec_pkg::*;
#(
  parameter int DLEN  = DLEN_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int WPORT = 2,
  parameter int RPORT = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clk_en_i,
  input  logic                                   clr_i,
  input  logic [WPORT-1:0]                       wr_en_i,
  input  logic [WPORT-1:0][DLEN/8-1:0]           wr_be_i,
  input  logic [WPORT-1:0][$clog2(NREG)-1:0]     wr_addr_i,
  input  logic [WPORT-1:0][DLEN-1:0]             wr_data_i,
  input  logic [RPORT-1:0]                       rd_en_i,
  input  logic [RPORT-1:0][$clog2(NREG)-1:0]     rd_addr_i,
  output logic [RPORT-1:0][DLEN-1:0]             rd_data_o,
  output logic                                   busy_o,
  output logic                                   wr_conflict_o
);

  localparam int             AW       = $clog2(NREG);
  localparam logic [AW-1:0]  LAST_IDX = AW'(NREG - 1);

  vrf_state_e                state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic                      run;
  logic [WPORT-1:0]          wr_go;

  logic [DLEN-1:0]           regs_q [NREG];
  logic [DLEN-1:0]           regs_d [NREG];
  logic [DLEN-1:0]           rd_byp [RPORT];

  logic [RPORT-1:0][DLEN-1:0] rd_data_q, rd_data_d;
  logic                      conflict_q, conflict_d;

  // --------------------------------------------------------------------------
  // Sweep / run control
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      INIT: begin
        idx_d = idx_q + AW'(1);
        if (clr_i) begin
          idx_d = '0;
        end else if (idx_q == LAST_IDX) begin
          state_d = RUN;
          idx_d   = '0;
        end
      end
      RUN: begin
        if (clr_i) begin
          state_d = INIT;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        idx_d   = '0;
      end
    endcase
  end

  assign run    = (state_q == RUN);
  // busy decodes the state flop directly, so no input reaches it combinationally.
  assign busy_o = (state_q == INIT);
  assign wr_go  = wr_en_i & {WPORT{run}};

  // --------------------------------------------------------------------------
  // Storage update: one merge per register
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < NREG; r++) begin : g_reg
    logic [WPORT-1:0] match;
    always_comb begin
      for (int p = 0; p < WPORT; p++) begin
        match[p] = (wr_addr_i[p] == AW'(r));
      end
    end

    vec_be_merge #(
      .DLEN  (DLEN),
      .WPORT (WPORT)
    ) u_merge (
      .base_i   (regs_q[r]),
      .en_i     (wr_go),
      .match_i  (match),
      .be_i     (wr_be_i),
      .data_i   (wr_data_i),
      .merged_o (regs_d[r])
    );
  end

  // Storage has no reset of its own; the sweep zeroes one register per cycle.
  always_ff @(posedge clk) begin
    if (!rst && clk_en_i) begin
      for (int r = 0; r < NREG; r++) begin
        if (!run) begin
          if (idx_q == AW'(r)) begin
            regs_q[r] <= '0;
          end
        end else begin
          regs_q[r] <= regs_d[r];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read ports: bypass merge gives the post-write value of the addressed word
  // --------------------------------------------------------------------------
  for (genvar q = 0; q < RPORT; q++) begin : g_rd
    logic [WPORT-1:0] match;
    always_comb begin
      for (int p = 0; p < WPORT; p++) begin
        match[p] = (wr_addr_i[p] == rd_addr_i[q]);
      end
    end

    vec_be_merge #(
      .DLEN  (DLEN),
      .WPORT (WPORT)
    ) u_byp (
      .base_i   (regs_q[rd_addr_i[q]]),
      .en_i     (wr_go),
      .match_i  (match),
      .be_i     (wr_be_i),
      .data_i   (wr_data_i),
      .merged_o (rd_byp[q])
    );
  end

  always_comb begin
    for (int q = 0; q < RPORT; q++) begin
      rd_data_d[q] = rd_data_q[q];
      if (!run || clr_i) begin
        rd_data_d[q] = '0;
      end else if (rd_en_i[q]) begin
        rd_data_d[q] = rd_byp[q];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Write conflict: any two enabled ports hitting a common byte of one register
  // --------------------------------------------------------------------------
  always_comb begin
    conflict_d = 1'b0;
    for (int p = 0; p < WPORT; p++) begin
      for (int p2 = p + 1; p2 < WPORT; p2++) begin
        if (wr_go[p] && wr_go[p2] && (wr_addr_i[p] == wr_addr_i[p2]) &&
            (|(wr_be_i[p] & wr_be_i[p2]))) begin
          conflict_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q  <= '0;
      conflict_q <= 1'b0;
    end else if (clk_en_i) begin
      rd_data_q  <= rd_data_d;
      conflict_q <= conflict_d;
    end
  end

  assign rd_data_o     = rd_data_q;
  assign wr_conflict_o = conflict_q;

endmodule : vec_regfile
`default_nettype wire

// File: tb/tb_vec_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_regfile
//  Description : Self-checking bench for vec_regfile. A register-array model
//                tracks the architectural state edge by edge; directed
//                scenarios plus random traffic are compared every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_regfile;
  import vec_pkg::*;

  localparam int DLEN  = 128;
  localparam int NREG  = 32;
  localparam int WPORT = 2;
  localparam int RPORT = 3;
  localparam int NB    = DLEN / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                             rst;
  logic                             clk_en;
  logic                             clr;
  logic [WPORT-1:0]                 wr_en;
  logic [WPORT-1:0][NB-1:0]         wr_be;
  logic [WPORT-1:0][4:0]            wr_addr;
  logic [WPORT-1:0][DLEN-1:0]       wr_data;
  logic [RPORT-1:0]                 rd_en;
  logic [RPORT-1:0][4:0]            rd_addr;
  logic [RPORT-1:0][DLEN-1:0]       rd_data;
  logic                             busy;
  logic                             wr_conflict;

  vec_regfile #(
    .DLEN  (DLEN),
    .NREG  (NREG),
    .WPORT (WPORT),
    .RPORT (RPORT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en_i      (clk_en),
    .clr_i         (clr),
    .wr_en_i       (wr_en),
    .wr_be_i       (wr_be),
    .wr_addr_i     (wr_addr),
    .wr_data_i     (wr_data),
    .rd_en_i       (rd_en),
    .rd_addr_i     (rd_addr),
    .rd_data_o     (rd_data),
    .busy_o        (busy),
    .wr_conflict_o (wr_conflict)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [DLEN-1:0] got, input logic [DLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DLEN-1:0] m_mem [NREG];
  logic [DLEN-1:0] m_rd  [RPORT];
  bit              m_init = 1'b1;
  int              m_idx  = 0;
  bit              m_conf = 1'b0;

  task automatic model_edge();
    logic [DLEN-1:0] nm [NREG];
    int              cnt [NREG][NB];
    if (rst) begin
      m_init = 1'b1;
      m_idx  = 0;
      m_conf = 1'b0;
      for (int q = 0; q < RPORT; q++) m_rd[q] = '0;
    end else if (clk_en) begin
      if (m_init) begin
        m_mem[m_idx] = '0;
        m_conf = 1'b0;
        if (clr) m_idx = 0;
        else if (m_idx == NREG - 1) begin
          m_init = 1'b0;
          m_idx  = 0;
        end else m_idx++;
      end else begin
        nm = m_mem;
        for (int r = 0; r < NREG; r++)
          for (int b = 0; b < NB; b++) cnt[r][b] = 0;
        for (int p = 0; p < WPORT; p++)
          if (wr_en[p])
            for (int b = 0; b < NB; b++)
              if (wr_be[p][b]) begin
                nm[wr_addr[p]][8*b +: 8] = wr_data[p][8*b +: 8];
                cnt[wr_addr[p]][b]++;
              end
        m_conf = 1'b0;
        for (int r = 0; r < NREG; r++)
          for (int b = 0; b < NB; b++)
            if (cnt[r][b] > 1) m_conf = 1'b1;
        for (int q = 0; q < RPORT; q++) begin
          if (clr) m_rd[q] = '0;
          else if (rd_en[q]) m_rd[q] = nm[rd_addr[q]];
        end
        m_mem = nm;
        if (clr) begin
          m_init = 1'b1;
          m_idx  = 0;
        end
      end
    end
  endtask

  // One clock edge: advance model with the inputs seen at the edge, then compare.
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("busy", DLEN'(busy), DLEN'(m_init));
    check("wr_conflict", DLEN'(wr_conflict), DLEN'(m_conf));
    for (int q = 0; q < RPORT; q++)
      check($sformatf("rd_data%0d", q), rd_data[q], m_rd[q]);
  endtask

  task automatic idle();
    wr_en = '0; wr_be = '0; wr_addr = '0; wr_data = '0;
    rd_en = '0; rd_addr = '0;
  endtask

  function automatic logic [DLEN-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic rand_inputs();
    for (int p = 0; p < WPORT; p++) begin
      wr_en[p]   = ($urandom_range(0, 2) != 0);
      wr_be[p]   = NB'($urandom);
      wr_addr[p] = 5'($urandom_range(0, 7));
      wr_data[p] = rand_word();
    end
    for (int q = 0; q < RPORT; q++) begin
      rd_en[q]   = ($urandom_range(0, 1) != 0);
      rd_addr[q] = 5'($urandom_range(0, 7));
    end
  endtask

  task automatic write1(input int p, input vreg_addr_t a, input logic [NB-1:0] be,
                        input logic [DLEN-1:0] d);
    wr_en[p] = 1'b1; wr_addr[p] = a; wr_be[p] = be; wr_data[p] = d;
  endtask

  // Runs cycles with random (ignored) traffic until busy drops; returns cycle count.
  task automatic count_sweep(output int n);
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      rand_inputs();
      tick();
      n++;
    end
    idle();
  endtask

  task automatic read_all();
    for (int r = 0; r < NREG; r += RPORT) begin
      idle();
      for (int q = 0; q < RPORT; q++) begin
        rd_en[q]   = 1'b1;
        rd_addr[q] = 5'((r + q) % NREG);
      end
      tick();
    end
    idle();
  endtask

  int n;

  initial begin
    for (int r = 0; r < NREG; r++) m_mem[r] = '0;
    for (int q = 0; q < RPORT; q++) m_rd[q] = '0;
    idle();
    clr = 1'b0; clk_en = 1'b1; rst = 1'b1;

    // Reset with write/read attempts
    repeat (3) begin rand_inputs(); tick(); end
    rst = 1'b0;
    count_sweep(n);
    check("reset_sweep_len", DLEN'(n), DLEN'(32));
    read_all();
    for (int q = 0; q < RPORT; q++) check("reset_read_zero", rd_data[q], '0);

    // Byte merge
    idle(); write1(0, 5'd5, '1, {NB{8'hAA}}); tick();
    idle(); write1(0, 5'd5, 16'h0001, {120'h0, 8'h11}); tick();
    idle(); rd_en[0] = 1'b1; rd_addr[0] = 5'd5; tick();
    check("byte_merge", rd_data[0], {{15{8'hAA}}, 8'h11});

    // Priority and conflict
    idle(); write1(0, 5'd7, '1, {NB{8'hCC}}); tick();
    idle(); write1(0, 5'd7, 16'h00FF, {NB{8'hA1}}); write1(1, 5'd7, 16'h0F0F, {NB{8'hB2}}); tick();
    check("conflict_pulse", DLEN'(wr_conflict), DLEN'(1));
    idle(); rd_en[2] = 1'b1; rd_addr[2] = 5'd7; tick();
    check("conflict_clear", DLEN'(wr_conflict), DLEN'(0));
    check("priority_merge", rd_data[2], {32'hCCCCCCCC, 32'hB2B2B2B2, 32'hA1A1A1A1, 32'hB2B2B2B2});

    // Bypass and hold
    idle(); write1(0, 5'd3, '1, 128'h1234); rd_en[1] = 1'b1; rd_addr[1] = 5'd3; tick();
    check("bypass", rd_data[1], 128'h1234);
    idle(); write1(1, 5'd3, '1, 128'h5678); rd_addr[1] = 5'd3; tick();
    idle(); tick();
    check("rd_hold", rd_data[1], 128'h1234);

    // clk_en freeze in the middle of a sweep
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    repeat (10) begin rand_inputs(); tick(); end
    clk_en = 1'b0;
    repeat (5) begin rand_inputs(); tick(); end
    clk_en = 1'b1;
    count_sweep(n);
    check("freeze_sweep_len", DLEN'(n + 15), DLEN'(37));

    // Random traffic with occasional clears and stalls
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      clk_en = ($urandom_range(0, 9) != 0);
      clr    = ($urandom_range(0, 149) == 0);
      tick();
    end
    clk_en = 1'b1; clr = 1'b0; idle();
    count_sweep(n);

    // Fill, soft clear, verify zeroes
    for (int r = 0; r < NREG; r++) begin
      idle(); write1(r % WPORT, 5'(r), '1, rand_word()); tick();
    end
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    count_sweep(n);
    check("clr_sweep_len", DLEN'(n), DLEN'(32));
    read_all();
    for (int q = 0; q < RPORT; q++) check("clr_read_zero", rd_data[q], '0);

    // Reset at sweep index 10 restarts a full sweep
    idle(); write1(0, 5'd20, '1, rand_word()); tick();
    idle(); clr = 1'b1; tick(); clr = 1'b0;
    repeat (10) tick();
    rst = 1'b1; tick(); rst = 1'b0;
    count_sweep(n);
    check("rst_restart_len", DLEN'(n), DLEN'(32));
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_vec_regfile
`default_nettype wire
